// File: rtl/api_rx_parser.sv
// api_rx_parser
//   Pulls fixed-length result blocks out of the API controller's RX FIFO and
//   checks the trailer tag and the nonce magic. Blocks that carry a nonce go
//   out on the host-side stream with their miner id. Everything else is
//   counted and dropped.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   i_en                  start enable, sampled only while idle
//   o_rx_fifo_rd_en       FIFO pop; the data arrives one cycle later
//   i_rx_fifo_dout        FIFO read data
//   i_rx_fifo_data_count  FIFO occupancy in words
//   o_blk_vld/i_blk_rdy   output word handshake
//   o_blk_dat             output word
//   o_blk_last            final word of the block
//   o_blk_miner_id        low nibble of the trailer word, stable for the block
//   o_busy                parser is not idle
//   i_clr_cnt             clears all statistics counters
//   o_nonce_cnt           blocks forwarded (saturating)
//   o_drop_cnt            well-formed blocks without the magic (saturating)
//   o_err_cnt             blocks with a bad trailer tag (saturating)
//
// state | meaning
// IDLE  | waiting for i_en and a full block in the FIFO
// READ  | popping BLK_LEN words and capturing them into the buffer
// CHECK | one cycle: validate the tag, then the magic
// SEND  | streaming the buffered block out under blk_vld/blk_rdy
module api_rx_parser #(
  parameter int          BLK_LEN   = 11,
  parameter int          MAGIC_IDX = 9,
  parameter logic [31:0] MAGIC     = 32'hbeafbeaf,
  parameter logic [7:0]  TAG       = 8'h12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic        o_rx_fifo_rd_en,
  input  logic [31:0] i_rx_fifo_dout,
  input  logic [9:0]  i_rx_fifo_data_count,
  output logic        o_blk_vld,
  input  logic        i_blk_rdy,
  output logic [31:0] o_blk_dat,
  output logic        o_blk_last,
  output logic [3:0]  o_blk_miner_id,
  output logic        o_busy,
  input  logic        i_clr_cnt,
  output logic [15:0] o_nonce_cnt,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int            CW       = $clog2(BLK_LEN + 1);
  localparam logic [CW-1:0] LEN_C    = CW'(BLK_LEN);
  localparam logic [CW-1:0] LAST_IDX = CW'(BLK_LEN - 1);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic [1:0] {IDLE, READ, CHECK, SEND} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [31:0]   r_buf [BLK_LEN];
  logic [CW-1:0] r_rd_cnt;
  logic [CW-1:0] r_cap_cnt;
  logic [CW-1:0] r_out_idx;
  logic          r_rd_en_d1;
  logic [3:0]    r_miner_id;
  logic [15:0]   r_nonce_cnt;
  logic [15:0]   r_drop_cnt;
  logic [15:0]   r_err_cnt;

  logic          w_start;
  logic          w_rd_en;
  logic          w_tag_ok;
  logic          w_magic_ok;
  logic          w_inc_nonce;
  logic          w_inc_drop;
  logic          w_inc_err;
  logic          w_send_hs;

  assign w_tag_ok   = (r_buf[BLK_LEN-1][15:8] == TAG);
  assign w_magic_ok = (r_buf[MAGIC_IDX] == MAGIC);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_start         = 1'b0;
    w_rd_en         = 1'b0;
    w_inc_nonce     = 1'b0;
    w_inc_drop      = 1'b0;
    w_inc_err       = 1'b0;
    w_send_hs       = 1'b0;
    o_blk_vld       = 1'b0;
    o_blk_dat       = '0;
    o_blk_last      = 1'b0;
    o_busy          = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (i_en && (i_rx_fifo_data_count >= 10'(BLK_LEN))) begin
          w_start     = 1'b1;
          w_state_nxt = READ;
        end
      end
      READ: begin
        w_rd_en = (r_rd_cnt < LEN_C);
        // Leave once the final popped word has landed in the buffer.
        if (r_rd_en_d1 && (r_cap_cnt == LAST_IDX)) begin
          w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        // A bad tag makes the block malformed regardless of the magic.
        if (!w_tag_ok) begin
          w_inc_err   = 1'b1;
          w_state_nxt = IDLE;
        end else if (!w_magic_ok) begin
          w_inc_drop  = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_inc_nonce = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        o_blk_vld  = 1'b1;
        o_blk_dat  = r_buf[r_out_idx];
        o_blk_last = (r_out_idx == LAST_IDX);
        w_send_hs  = i_blk_rdy;
        if (i_blk_rdy && (r_out_idx == LAST_IDX)) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign o_rx_fifo_rd_en = w_rd_en;
  assign o_blk_miner_id  = r_miner_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_cnt   <= '0;
      r_cap_cnt  <= '0;
      r_out_idx  <= '0;
      r_rd_en_d1 <= 1'b0;
      r_miner_id <= '0;
      for (int i = 0; i < BLK_LEN; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_rd_en_d1 <= w_rd_en;
      if (w_start) begin
        r_rd_cnt  <= '0;
        r_cap_cnt <= '0;
      end
      if (w_rd_en) begin
        r_rd_cnt <= r_rd_cnt + ONE_C;
      end
      // FIFO data lags the pop by one cycle, so capture on the delayed strobe.
      if (r_rd_en_d1) begin
        r_buf[r_cap_cnt] <= i_rx_fifo_dout;
        r_cap_cnt        <= r_cap_cnt + ONE_C;
      end
      // Latch the miner id before SEND so it cannot move during the block.
      if (r_state == CHECK) begin
        r_out_idx  <= '0;
        r_miner_id <= r_buf[BLK_LEN-1][3:0];
      end
      if (w_send_hs) begin
        r_out_idx <= r_out_idx + ONE_C;
      end
    end
  end

  // Clear beats a coincident increment; counters stick at all-ones.
  always_ff @(posedge clk) begin
    if (rst || i_clr_cnt) begin
      r_nonce_cnt <= '0;
      r_drop_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      if (w_inc_nonce && (r_nonce_cnt != 16'hFFFF)) begin
        r_nonce_cnt <= r_nonce_cnt + 16'd1;
      end
      if (w_inc_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      if (w_inc_err && (r_err_cnt != 16'hFFFF)) begin
        r_err_cnt <= r_err_cnt + 16'd1;
      end
    end
  end

  assign o_nonce_cnt = r_nonce_cnt;
  assign o_drop_cnt  = r_drop_cnt;
  assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_api_rx_parser.sv
// tb_api_rx_parser
//   Drives api_rx_parser from a queue-backed FIFO model and checks the output
//   stream against a scoreboard of expected words, plus counter and timing
//   checks for the block types and corner cases of the parser.
module tb_api_rx_parser;

  localparam int          BLK_LEN = 11;
  localparam logic [31:0] MAGIC   = 32'hbeafbeaf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic        o_rx_fifo_rd_en;
  logic [31:0] i_rx_fifo_dout = '0;
  logic [9:0]  i_rx_fifo_data_count = '0;
  logic        o_blk_vld;
  logic        i_blk_rdy = 1'b1;
  logic [31:0] o_blk_dat;
  logic        o_blk_last;
  logic [3:0]  o_blk_miner_id;
  logic        o_busy;
  logic        i_clr_cnt = 1'b0;
  logic [15:0] o_nonce_cnt;
  logic [15:0] o_drop_cnt;
  logic [15:0] o_err_cnt;

  api_rx_parser dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_en                 (i_en),
    .o_rx_fifo_rd_en      (o_rx_fifo_rd_en),
    .i_rx_fifo_dout       (i_rx_fifo_dout),
    .i_rx_fifo_data_count (i_rx_fifo_data_count),
    .o_blk_vld            (o_blk_vld),
    .i_blk_rdy            (i_blk_rdy),
    .o_blk_dat            (o_blk_dat),
    .o_blk_last           (o_blk_last),
    .o_blk_miner_id       (o_blk_miner_id),
    .o_busy               (o_busy),
    .i_clr_cnt            (i_clr_cnt),
    .o_nonce_cnt          (o_nonce_cnt),
    .o_drop_cnt           (o_drop_cnt),
    .o_err_cnt            (o_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] dat;
    logic        last;
    logic [3:0]  miner;
  } exp_t;

  typedef struct {
    logic [31:0] w9;
    logic [31:0] w10;
    bit          fwd;
    bit          drop;
    bit          err;
  } vec_t;

  exp_t        exp_q[$];
  exp_t        sb_e;
  logic [31:0] fifo_q[$];
  logic [31:0] fifo_tmp;
  logic [31:0] blk_w [BLK_LEN];
  int          blk_seq = 0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int pop_total = 0;
  int acc_total = 0;
  int pop_starts[$];
  int vld_starts[$];
  int idle_at[$];
  int last_hs[$];

  logic        pop_pending = 1'b0;
  logic        m_rd_prev   = 1'b0;
  logic        m_busy_prev = 1'b0;
  logic        m_vld_prev  = 1'b0;
  logic        m_rdy_prev  = 1'b0;
  logic [31:0] m_dat_prev  = '0;

  logic [15:0] m_nonce = '0;
  logic [15:0] m_drop  = '0;
  logic [15:0] m_err   = '0;

  bit          bp_mode = 1'b0;
  int          bp_i = 0;
  logic [3:0]  bp_pat = 4'b1001;

  function automatic logic [15:0] sat(input logic [15:0] x);
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // FIFO model: pops decided at the previous falling edge, data one cycle later.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop_pending) begin
      if (fifo_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL fifo_underflow: got pop expected no pop (t=%0t)", $time);
      end else begin
        fifo_tmp = fifo_q.pop_front();
        i_rx_fifo_dout <= fifo_tmp;
      end
    end
    i_rx_fifo_data_count <= 10'(fifo_q.size());
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode) begin
      i_blk_rdy = bp_pat[bp_i % 4];
      bp_i++;
    end else begin
      i_blk_rdy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pop_pending = 1'b0;
      m_rd_prev   = 1'b0;
      m_busy_prev = 1'b0;
      m_vld_prev  = 1'b0;
      m_rdy_prev  = 1'b0;
    end else begin
      pop_pending = o_rx_fifo_rd_en;
      if (o_rx_fifo_rd_en) begin
        pop_total++;
        if (!m_rd_prev) pop_starts.push_back(cyc);
      end
      if (m_busy_prev && !o_busy) idle_at.push_back(cyc);
      if (o_blk_vld && !m_vld_prev) vld_starts.push_back(cyc);
      if (m_vld_prev && !m_rdy_prev) begin
        chk("stall_vld", 32'(o_blk_vld), 32'd1);
        chk("stall_dat", o_blk_dat, m_dat_prev);
      end
      if (o_blk_vld && i_blk_rdy) begin
        acc_total++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_word: got %h expected no output", o_blk_dat);
        end else begin
          sb_e = exp_q.pop_front();
          chk("blk_dat", o_blk_dat, sb_e.dat);
          chk("blk_last", 32'(o_blk_last), 32'(sb_e.last));
          chk("blk_miner_id", 32'(o_blk_miner_id), 32'(sb_e.miner));
        end
        if (o_blk_last) last_hs.push_back(cyc);
      end
      m_rd_prev   = o_rx_fifo_rd_en;
      m_busy_prev = o_busy;
      m_vld_prev  = o_blk_vld;
      m_rdy_prev  = i_blk_rdy;
      m_dat_prev  = o_blk_dat;
    end
  end

  task automatic make_block(input logic [31:0] w9, input logic [31:0] w10);
    for (int k = 0; k < BLK_LEN; k++) begin
      blk_w[k] = {8'hA0 + 8'(blk_seq), 16'h5A00, 8'(k)};
    end
    blk_w[9]  = w9;
    blk_w[10] = w10;
    blk_seq++;
  endtask

  task automatic push_words(input int lo, input int hi);
    for (int k = lo; k < hi; k++) fifo_q.push_back(blk_w[k]);
  endtask

  task automatic expect_fwd();
    for (int k = 0; k < BLK_LEN; k++) begin
      exp_q.push_back('{blk_w[k], (k == BLK_LEN - 1), blk_w[10][3:0]});
    end
  endtask

  task automatic drain(input string nm);
    bit done = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      #1;
      if (!o_busy && exp_q.size() == 0 && (fifo_q.size() < BLK_LEN || !i_en)) begin
        done = 1'b1;
        break;
      end
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic wait_pops(input int target, input string nm);
    bit done = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      #1;
      if (pop_total >= target) begin
        done = 1'b1;
        break;
      end
    end
    chk({nm, "_pops_reached"}, 32'(done), 32'd1);
  endtask

  task automatic chk_counts(input string nm);
    chk({nm, "_nonce_cnt"}, 32'(o_nonce_cnt), 32'(m_nonce));
    chk({nm, "_drop_cnt"},  32'(o_drop_cnt),  32'(m_drop));
    chk({nm, "_err_cnt"},   32'(o_err_cnt),   32'(m_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[6];
  int   base_pop;
  int   base_acc;

  initial begin
    vecs[0] = '{32'hbeafbeaf, 32'hABCD1203, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h00000000, 32'h00001212, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'hbeafbeaf, 32'h00003405, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'hbeafbeaf, 32'h1234120F, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{32'hbeafbeae, 32'hFFFF12FF, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{32'h00000000, 32'h00001300, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",     32'(o_busy),          32'd0);
    chk("rst_rd_en",    32'(o_rx_fifo_rd_en), 32'd0);
    chk("rst_vld",      32'(o_blk_vld),       32'd0);
    chk("rst_last",     32'(o_blk_last),      32'd0);
    chk("rst_dat",      o_blk_dat,            32'd0);
    chk("rst_miner_id", 32'(o_blk_miner_id),  32'd0);
    chk_counts("rst");
    rst = 1'b0;
    i_en = 1'b1;

    for (int v = 0; v < 6; v++) begin
      pop_starts.delete();
      vld_starts.delete();
      idle_at.delete();
      base_pop = pop_total;
      base_acc = acc_total;
      make_block(vecs[v].w9, vecs[v].w10);
      if (vecs[v].fwd) begin
        expect_fwd();
        m_nonce = sat(m_nonce);
      end
      if (vecs[v].drop) m_drop = sat(m_drop);
      if (vecs[v].err)  m_err  = sat(m_err);
      push_words(0, BLK_LEN);
      drain("vec");
      chk("vec_pops", 32'(pop_total - base_pop), 32'(BLK_LEN));
      chk("vec_words_out", 32'(acc_total - base_acc), vecs[v].fwd ? 32'(BLK_LEN) : 32'd0);
      chk_counts("vec");
      chk("vec_pop_bursts", 32'(pop_starts.size()), 32'd1);
      if (pop_starts.size() > 0) begin
        if (vecs[v].fwd) begin
          chk("vec_vld_latency", (vld_starts.size() > 0) ? 32'(vld_starts[0] - pop_starts[0]) : 32'hFFFFFFFF, 32'd13);
        end else begin
          chk("vec_idle_after_check", (idle_at.size() > 0) ? 32'(idle_at[0] - pop_starts[0]) : 32'hFFFFFFFF, 32'd13);
        end
      end
    end

    // Backpressure: rdy pattern 1,0,0,1 repeating.
    base_pop = pop_total;
    base_acc = acc_total;
    bp_mode = 1'b1;
    make_block(MAGIC, 32'h00001209);
    expect_fwd();
    m_nonce = sat(m_nonce);
    push_words(0, BLK_LEN);
    drain("bp");
    bp_mode = 1'b0;
    chk("bp_pops", 32'(pop_total - base_pop), 32'(BLK_LEN));
    chk("bp_words_out", 32'(acc_total - base_acc), 32'(BLK_LEN));
    chk_counts("bp");

    // Threshold: one word short must not start.
    base_pop = pop_total;
    make_block(MAGIC, 32'h00001207);
    push_words(0, BLK_LEN - 1);
    repeat (20) @(posedge clk);
    #1;
    chk("thr10_pops", 32'(pop_total - base_pop), 32'd0);
    chk("thr10_busy", 32'(o_busy), 32'd0);
    expect_fwd();
    m_nonce = sat(m_nonce);
    push_words(BLK_LEN - 1, BLK_LEN);
    drain("thr11");
    chk("thr11_pops", 32'(pop_total - base_pop), 32'(BLK_LEN));
    chk_counts("thr11");

    // Enable dropped mid-block: current block completes, next does not start.
    base_pop = pop_total;
    make_block(MAGIC, 32'h00001201);
    expect_fwd();
    m_nonce = sat(m_nonce);
    push_words(0, BLK_LEN);
    wait_pops(base_pop + 3, "en_drop");
    i_en = 1'b0;
    make_block(32'h0, 32'h00001200);
    push_words(0, BLK_LEN);
    drain("en_drop");
    chk("en_drop_pops", 32'(pop_total - base_pop), 32'(BLK_LEN));
    repeat (15) @(posedge clk);
    #1;
    chk("en_drop_no_start", 32'(o_busy), 32'd0);
    chk("en_drop_pops_held", 32'(pop_total - base_pop), 32'(BLK_LEN));
    chk_counts("en_drop");
    i_en = 1'b1;
    m_drop = sat(m_drop);
    drain("en_resume");
    chk("en_resume_pops", 32'(pop_total - base_pop), 32'(2 * BLK_LEN));
    chk_counts("en_resume");

    // Two blocks queued at once run back to back.
    base_pop = pop_total;
    base_acc = acc_total;
    pop_starts.delete();
    last_hs.delete();
    make_block(MAGIC, 32'h00001204);
    expect_fwd();
    push_words(0, BLK_LEN);
    make_block(MAGIC, 32'h00001205);
    expect_fwd();
    push_words(0, BLK_LEN);
    m_nonce = sat(sat(m_nonce));
    drain("b2b");
    chk("b2b_pops", 32'(pop_total - base_pop), 32'(2 * BLK_LEN));
    chk("b2b_words_out", 32'(acc_total - base_acc), 32'(2 * BLK_LEN));
    chk("b2b_gap", (pop_starts.size() == 2 && last_hs.size() == 2) ? 32'(pop_starts[1] - last_hs[0]) : 32'hFFFFFFFF, 32'd2);
    chk_counts("b2b");

    // clr_cnt in the CHECK cycle wins over the increment.
    base_pop = pop_total;
    make_block(MAGIC, 32'h00001206);
    expect_fwd();
    push_words(0, BLK_LEN);
    wait_pops(base_pop + BLK_LEN, "clr");
    @(posedge clk);
    @(posedge clk);
    #1;
    i_clr_cnt = 1'b1;
    @(posedge clk);
    #1;
    i_clr_cnt = 1'b0;
    m_nonce = '0;
    m_drop  = '0;
    m_err   = '0;
    drain("clr");
    chk_counts("clr");

    // Saturation from a preloaded value.
    force dut.r_nonce_cnt = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.r_nonce_cnt;
    m_nonce = 16'hFFFE;
    chk("sat_preload", 32'(o_nonce_cnt), 32'(m_nonce));
    for (int s = 0; s < 2; s++) begin
      make_block(MAGIC, 32'h0000120A);
      expect_fwd();
      m_nonce = sat(m_nonce);
      push_words(0, BLK_LEN);
      drain("sat");
      chk("sat_nonce_cnt", 32'(o_nonce_cnt), 32'h0000FFFF);
    end

    // Reset in the middle of READ discards everything.
    base_pop = pop_total;
    make_block(MAGIC, 32'h0000120B);
    push_words(0, BLK_LEN);
    wait_pops(base_pop + 4, "rst_mid");
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_busy",  32'(o_busy),          32'd0);
    chk("rst_mid_rd_en", 32'(o_rx_fifo_rd_en), 32'd0);
    chk("rst_mid_vld",   32'(o_blk_vld),       32'd0);
    @(posedge clk);
    #1;
    fifo_q.delete();
    exp_q.delete();
    rst = 1'b0;
    m_nonce = '0;
    m_drop  = '0;
    m_err   = '0;
    chk_counts("rst_mid");
    repeat (10) @(posedge clk);
    #1;
    chk("rst_mid_idle", 32'(o_busy), 32'd0);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/api_rx_parser.md
Name: api_rx_parser

Overview:
- Sits directly downstream of the API controller's RX FIFO.
- Pops fixed-length 11-word result blocks from the FIFO and validates the trailer tag and nonce magic.
- Forwards only nonce-bearing blocks to the host-side stream interface, with a per-block miner id.
- Keeps saturating statistics for forwarded, dropped and malformed blocks.

Parameters:
BLK_LEN, 11, words per result block; only 11 is required to work
MAGIC_IDX, 9, word index within the block that carries the nonce magic
MAGIC, 32'hbeafbeaf, magic value marking a block that carries a nonce
TAG, 8'h12, required value of bits [15:8] of the last block word

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
en  input  1  start enable; sampled only in IDLE
rx_fifo_rd_en  output  1  RX FIFO pop; read data appears one cycle later
rx_fifo_dout  input  32  RX FIFO read data
rx_fifo_data_count  input  10  RX FIFO occupancy in words
blk_vld  output  1  output word valid
blk_rdy  input  1  output word accept
blk_dat  output  32  output word
blk_last  output  1  marks the final word of a block (index BLK_LEN-1)
blk_miner_id  output  4  last block word [3:0]; held stable for the whole block
busy  output  1  high when state != IDLE
clr_cnt  input  1  synchronous clear of all statistics counters
nonce_cnt  output  16  blocks forwarded; saturates at 16'hFFFF
drop_cnt  output  16  well-formed blocks without magic; saturates
err_cnt  output  16  blocks with a bad tag; saturates

Behaviour:
- Reset values:
  - state = IDLE.
  - rx_fifo_rd_en = 0, blk_vld = 0, blk_last = 0.
  - blk_dat = 0, blk_miner_id = 0.
  - All counters = 0, busy = 0.
  - Internal rd_cnt, cap_cnt and out_idx = 0.
- Block buffer: BLK_LEN x 32-bit registers, buf[0..BLK_LEN-1].
- FSM states: IDLE, READ, CHECK, SEND.
- IDLE:
  - Go to READ when en && rx_fifo_data_count >= BLK_LEN.
  - Clear rd_cnt and cap_cnt on this transition.
- READ:
  - rx_fifo_rd_en = (state == READ) && (rd_cnt < BLK_LEN).
  - Exactly BLK_LEN consecutive pops; no gaps, never more than BLK_LEN.
  - rd_en_d1 is rx_fifo_rd_en registered; when rd_en_d1 is high, buf[cap_cnt] <= rx_fifo_dout and cap_cnt increments.
  - Go to CHECK in the cycle after capturing word BLK_LEN-1.
  - rd_en is never asserted outside READ.
- CHECK (one cycle):
  - If buf[BLK_LEN-1][15:8] != TAG: err_cnt++, go to IDLE.
  - Else if buf[MAGIC_IDX] != MAGIC: drop_cnt++, go to IDLE.
  - Else: nonce_cnt++, out_idx = 0, go to SEND.
  - The tag check has priority over the magic check.
- SEND:
  - blk_vld = 1, blk_dat = buf[out_idx], blk_last = (out_idx == BLK_LEN-1).
  - Advance out_idx on blk_vld && blk_rdy.
  - blk_dat is held stable while blk_rdy is low.
  - Go to IDLE after the handshake on the last word.
  - blk_miner_id is valid and constant for the whole SEND state.
- Latency: first pop at cycle C; CHECK at C+BLK_LEN+1; first blk_vld at C+BLK_LEN+2.
- Back-to-back: from IDLE, the next READ may start in the cycle after returning to IDLE.
- en deasserted mid-block: the current block completes (read, check and any send); no new block starts. Partial blocks are never abandoned.
- Counters:
  - Saturate at 16'hFFFF; no wrap.
  - If clr_cnt and an increment occur in the same cycle, clr wins and the counter becomes 0.
  - clr_cnt has no effect on the FSM.
- rst mid-operation: everything returns to reset values immediately; buffered data is discarded. FIFO words already popped are lost, which is acceptable because the FIFO is reset alongside.
- data_count exactly BLK_LEN-1: no start. Exactly BLK_LEN: start.

Test Plan:
- Valid block: FIFO holds 11 words, word9 = beafbeaf, word10 = 0xABCD1203, blk_rdy = 1 -> exactly 11 rd_en pulses; 11 output words in order; blk_last on word 10; blk_miner_id = 3; nonce_cnt = 1.
- No magic: word9 = 0, tag = 0x12 -> no blk_vld, drop_cnt = 1, FSM back in IDLE after CHECK, exactly 11 pops.
- Bad tag: word10[15:8] = 0x34 with word9 = beafbeaf -> err_cnt = 1, nonce_cnt = 0, no output.
- Backpressure: valid block with blk_rdy toggled 1,0,0,1,... -> blk_dat stable while stalled, no word lost or duplicated, blk_last only on the 11th accepted word.
- Threshold and enable:
  - data_count = 10 -> no rd_en.
  - data_count = 11 -> start.
  - en dropped after 3 pops -> block still completes with 11 pops total.
  - 22 words with en high -> two back-to-back blocks.
- Counter edges: nonce_cnt preloaded to 0xFFFF via 65535 blocks (or forced) -> stays 0xFFFF; clr_cnt asserted in the same cycle as CHECK -> counter reads 0.
